// File: rtl/ro_enc_intr_ctrl.sv
// Rotary-encoder event consumer: counts detents into a saturating signed
// accumulator, re-arms the decoder, and raises a rate-limited PS interrupt.
module ro_enc_intr_ctrl #(
  parameter int CNT_WIDTH   = 8,
  parameter int HOLDOFF_CYC = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [1:0]           i_ro_enc_data,
  output logic                 o_sw_intr_clear,
  input  logic                 i_intr_ack,
  output logic                 o_intr,
  output logic [CNT_WIDTH-1:0] o_step_cnt,
  output logic                 o_ovf
);

  localparam int HW = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;
  localparam logic [HW-1:0]        HOLD_LOAD = HW'(HOLDOFF_CYC);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN   = {1'b1, {(CNT_WIDTH-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_REARM} state_t;

  // Decoder handshake: a 01/10 code seen in IDLE is one event; the clear level
  // (state==REARM) holds until the decoder returns 00/11, so each detent
  // is consumed exactly once regardless of how long the code is held.
  state_t                 r_state, w_state_next;
  logic [CNT_WIDTH-1:0]   r_acc, w_acc_base, w_acc_next;
  logic                   r_ovf, w_ovf_base, w_ovf_next;
  logic [HW-1:0]          r_hold, w_hold_next;
  logic                   r_intr, w_intr_next;
  logic                   w_code_cw, w_code_ccw, w_code_evt, w_count;

  assign w_code_cw  = (i_ro_enc_data == 2'b01);
  assign w_code_ccw = (i_ro_enc_data == 2'b10);
  assign w_code_evt = w_code_cw | w_code_ccw;
  assign w_count    = (r_state == ST_IDLE) & w_code_evt & i_en;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_code_evt)  w_state_next = ST_REARM;
      ST_REARM: if (!w_code_evt) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Ack clears first so an event in the same cycle lands on a zero base.
  always_comb begin
    w_acc_base = i_intr_ack ? '0 : r_acc;
    w_ovf_base = i_intr_ack ? 1'b0 : r_ovf;
    w_acc_next = w_acc_base;
    w_ovf_next = w_ovf_base;
    if (w_count) begin
      if (w_code_cw) begin
        if (w_acc_base == CNT_MAX) w_ovf_next = 1'b1;
        else                       w_acc_next = w_acc_base + CNT_WIDTH'(1);
      end else begin
        if (w_acc_base == CNT_MIN) w_ovf_next = 1'b1;
        else                       w_acc_next = w_acc_base - CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_hold_next = r_hold;
    if (i_intr_ack)       w_hold_next = HOLD_LOAD;
    else if (r_hold != '0) w_hold_next = r_hold - HW'(1);
    w_intr_next = (w_acc_next != '0) & (w_hold_next == '0) & ~i_intr_ack & i_en;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_hold  <= '0;
      r_intr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_ovf   <= w_ovf_next;
      r_hold  <= w_hold_next;
      r_intr  <= w_intr_next;
    end
  end

  assign o_sw_intr_clear = (r_state == ST_REARM);
  assign o_intr          = r_intr;
  assign o_step_cnt      = r_acc;
  assign o_ovf           = r_ovf;

endmodule

// File: tb/tb_ro_enc_intr_ctrl.sv
// Bench for ro_enc_intr_ctrl: an 8-bit and a 4-bit instance share stimulus;
// expected {intr, ovf, count} words are queued as stimulus is driven.
module tb_ro_enc_intr_ctrl;

  localparam int HOLD = 50;

  logic       clk = 1'b0;
  logic       rst, en, ack;
  logic [1:0] data;

  logic       o_sw_intr_clear, o_intr, o_ovf;
  logic [7:0] o_step_cnt;
  logic       clr4, intr4, ovf4;
  logic [3:0] cnt4;

  logic [9:0] exp_q[$];
  logic [5:0] exp4_q[$];
  logic [9:0] exp;
  logic [5:0] exp4;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ro_enc_intr_ctrl #(.CNT_WIDTH(8), .HOLDOFF_CYC(HOLD)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ro_enc_data(data),
    .o_sw_intr_clear(o_sw_intr_clear), .i_intr_ack(ack), .o_intr(o_intr),
    .o_step_cnt(o_step_cnt), .o_ovf(o_ovf)
  );

  ro_enc_intr_ctrl #(.CNT_WIDTH(4), .HOLDOFF_CYC(HOLD)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ro_enc_data(data),
    .o_sw_intr_clear(clr4), .i_intr_ack(ack), .o_intr(intr4),
    .o_step_cnt(cnt4), .o_ovf(ovf4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b1; en = 1'b1; ack = 1'b0; data = 2'b00;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; ack = 1'b1; data = 2'b01;
    exp_q.push_back(10'h000);
    exp4_q.push_back(6'h00);
    tick;
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp || o_sw_intr_clear !== 1'b0) begin
      failures++;
      $display("FAIL reset_w8: got clr=%b word=%h expected clr=0 word=%h", o_sw_intr_clear, {o_intr, o_ovf, o_step_cnt}, exp);
    end
    exp4 = exp4_q.pop_front(); checks++;
    if ({intr4, ovf4, cnt4} !== exp4 || clr4 !== 1'b0) begin
      failures++;
      $display("FAIL reset_w4: got clr=%b word=%h expected clr=0 word=%h", clr4, {intr4, ovf4, cnt4}, exp4);
    end
    rst = 1'b0; ack = 1'b0; data = 2'b00;
    tick;
  endtask

  task automatic test_cw_detent;
    logic [1:0] codes [3];
    logic       clrs  [3];
    codes[0] = 2'b01; codes[1] = 2'b00; codes[2] = 2'b11;
    clrs[0]  = 1'b1;  clrs[1]  = 1'b0;  clrs[2]  = 1'b0;
    apply_reset;
    for (int i = 0; i < 3; i++) begin
      data = codes[i];
      exp_q.push_back({1'b1, 1'b0, 8'd1});
      tick;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
        failures++;
        $display("FAIL cw_word[%0d]: got %h expected %h", i, {o_intr, o_ovf, o_step_cnt}, exp);
      end
      checks++;
      if (o_sw_intr_clear !== clrs[i]) begin
        failures++;
        $display("FAIL cw_clear[%0d]: got %b expected %b", i, o_sw_intr_clear, clrs[i]);
      end
    end
    data = 2'b00;
    tick;
  endtask

  task automatic test_ccw_ack;
    int n;
    apply_reset;
    for (int i = 1; i <= 3; i++) begin
      data = 2'b10;
      exp_q.push_back({1'b1, 1'b0, 8'(-i)});
      tick;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
        failures++;
        $display("FAIL ccw_word[%0d]: got %h expected %h", i, {o_intr, o_ovf, o_step_cnt}, exp);
      end
      data = 2'b00;
      tick;
    end
    ack = 1'b1;
    exp_q.push_back(10'h000);
    tick;
    ack = 1'b0;
    n = 0;
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
      failures++;
      $display("FAIL ack_clear: got %h expected %h", {o_intr, o_ovf, o_step_cnt}, exp);
    end
    for (int i = 0; i < 10; i++) begin tick; n++; end
    data = 2'b01;
    exp_q.push_back({1'b0, 1'b0, 8'd1});
    tick; n++;
    data = 2'b00;
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
      failures++;
      $display("FAIL holdoff_masked: got %h expected %h", {o_intr, o_ovf, o_step_cnt}, exp);
    end
    while (o_intr !== 1'b1 && n < 200) begin tick; n++; end
    checks++;
    if (n != HOLD) begin
      failures++;
      $display("FAIL intr_rise_after_ack: got %0d cycles expected %0d", n, HOLD);
    end
  endtask

  task automatic test_ack_with_event;
    int n;
    apply_reset;
    for (int i = 1; i <= 2; i++) begin
      data = 2'b01;
      exp_q.push_back({1'b1, 1'b0, 8'(i)});
      tick;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
        failures++;
        $display("FAIL pre_ack_word[%0d]: got %h expected %h", i, {o_intr, o_ovf, o_step_cnt}, exp);
      end
      data = 2'b00;
      tick;
    end
    data = 2'b01; ack = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 8'd1});
    tick;
    ack = 1'b0; data = 2'b00; n = 0;
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp || o_sw_intr_clear !== 1'b1) begin
      failures++;
      $display("FAIL ack_event_word: got clr=%b word=%h expected clr=1 word=%h", o_sw_intr_clear, {o_intr, o_ovf, o_step_cnt}, exp);
    end
    while (o_intr !== 1'b1 && n < 200) begin tick; n++; end
    checks++;
    if (n != HOLD) begin
      failures++;
      $display("FAIL ack_event_rise: got %0d cycles expected %0d", n, HOLD);
    end
    exp_q.push_back({1'b1, 1'b0, 8'd1});
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
      failures++;
      $display("FAIL ack_event_after_holdoff: got %h expected %h", {o_intr, o_ovf, o_step_cnt}, exp);
    end
  endtask

  task automatic test_saturation;
    apply_reset;
    for (int i = 1; i <= 9; i++) begin
      data = 2'b01;
      exp4_q.push_back({1'b1, (i >= 8), 4'((i <= 7) ? i : 7)});
      tick;
      exp4 = exp4_q.pop_front(); checks++;
      if ({intr4, ovf4, cnt4} !== exp4) begin
        failures++;
        $display("FAIL sat_pos[%0d]: got %h expected %h", i, {intr4, ovf4, cnt4}, exp4);
      end
      data = 2'b00;
      tick;
    end
    ack = 1'b1;
    exp4_q.push_back(6'h00);
    tick;
    ack = 1'b0;
    exp4 = exp4_q.pop_front(); checks++;
    if ({intr4, ovf4, cnt4} !== exp4) begin
      failures++;
      $display("FAIL sat_ack: got %h expected %h", {intr4, ovf4, cnt4}, exp4);
    end
    for (int i = 1; i <= 10; i++) begin
      data = 2'b10;
      exp4_q.push_back({1'b0, (i >= 9), 4'((i <= 8) ? -i : -8)});
      tick;
      exp4 = exp4_q.pop_front(); checks++;
      if ({intr4, ovf4, cnt4} !== exp4) begin
        failures++;
        $display("FAIL sat_neg[%0d]: got %h expected %h", i, {intr4, ovf4, cnt4}, exp4);
      end
      data = 2'b00;
      tick;
    end
    data = 2'b01; ack = 1'b1;
    exp4_q.push_back({1'b0, 1'b0, 4'd1});
    tick;
    data = 2'b00; ack = 1'b0;
    exp4 = exp4_q.pop_front(); checks++;
    if ({intr4, ovf4, cnt4} !== exp4) begin
      failures++;
      $display("FAIL sat_ack_event: got %h expected %h", {intr4, ovf4, cnt4}, exp4);
    end
    tick;
  endtask

  task automatic test_held_code;
    apply_reset;
    for (int i = 0; i < 20; i++) begin
      data = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_q.push_back({1'b1, 1'b0, 8'd1});
      tick;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp || o_sw_intr_clear !== 1'b1) begin
        failures++;
        $display("FAIL held_code[%0d]: got clr=%b word=%h expected clr=1 word=%h", i, o_sw_intr_clear, {o_intr, o_ovf, o_step_cnt}, exp);
      end
    end
    data = 2'b00;
    tick;
    checks++;
    if (o_sw_intr_clear !== 1'b0) begin
      failures++;
      $display("FAIL held_release: got clr=%b expected 0", o_sw_intr_clear);
    end
    data = 2'b01;
    exp_q.push_back({1'b1, 1'b0, 8'd2});
    tick;
    data = 2'b00;
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
      failures++;
      $display("FAIL held_next_event: got %h expected %h", {o_intr, o_ovf, o_step_cnt}, exp);
    end
    tick;
  endtask

  task automatic test_enable_and_rst;
    apply_reset;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data = 2'b01;
      exp_q.push_back(10'h000);
      tick;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp || o_sw_intr_clear !== 1'b1) begin
        failures++;
        $display("FAIL disabled_event[%0d]: got clr=%b word=%h expected clr=1 word=%h", i, o_sw_intr_clear, {o_intr, o_ovf, o_step_cnt}, exp);
      end
      data = 2'b00;
      tick;
      checks++;
      if (o_sw_intr_clear !== 1'b0) begin
        failures++;
        $display("FAIL disabled_release[%0d]: got clr=%b expected 0", i, o_sw_intr_clear);
      end
    end
    en = 1'b1; data = 2'b01;
    exp_q.push_back({1'b1, 1'b0, 8'd1});
    exp_q.push_back({1'b0, 1'b0, 8'd1});
    exp_q.push_back({1'b1, 1'b0, 8'd1});
    for (int i = 0; i < 3; i++) begin
      tick;
      data = 2'b00;
      en = (i == 0) ? 1'b0 : 1'b1;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp) begin
        failures++;
        $display("FAIL en_toggle[%0d]: got %h expected %h", i, {o_intr, o_ovf, o_step_cnt}, exp);
      end
    end
    data = 2'b01;
    tick;
    rst = 1'b1;
    exp_q.push_back(10'h000);
    tick;
    rst = 1'b0;
    exp = exp_q.pop_front(); checks++;
    if ({o_intr, o_ovf, o_step_cnt} !== exp || o_sw_intr_clear !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_rearm: got clr=%b word=%h expected clr=0 word=%h", o_sw_intr_clear, {o_intr, o_ovf, o_step_cnt}, exp);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b1, 1'b0, 8'd1});
      tick;
      exp = exp_q.pop_front(); checks++;
      if ({o_intr, o_ovf, o_step_cnt} !== exp || o_sw_intr_clear !== 1'b1) begin
        failures++;
        $display("FAIL recapture[%0d]: got clr=%b word=%h expected clr=1 word=%h", i, o_sw_intr_clear, {o_intr, o_ovf, o_step_cnt}, exp);
      end
    end
    data = 2'b00;
    tick;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; ack = 1'b0; data = 2'b00;
    test_reset;
    test_cw_detent;
    test_ccw_ack;
    test_ack_with_event;
    test_saturation;
    test_held_code;
    test_enable_and_rst;
    checks++;
    if (exp_q.size() != 0 || exp4_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp4_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
